// File: rtl/fetch_port_arbiter_pkg.sv
// Shared types for the instruction-fetch port arbiter: slot count, address and
// slot-index types, arbiter state encoding and a lowest-set-bit helper.
package fetch_port_arbiter_pkg;

    localparam int unsigned peval_width    = 2;
    localparam int unsigned fetch_slot_cnt = peval_width ** 2;

    typedef logic [31:0]                         addr_t;
    typedef logic [$clog2(fetch_slot_cnt)-1:0]   if_idx_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_DRAIN = 2'd2
    } fetch_arb_state_t;

    // Index of the lowest set bit; returns 0 for an empty mask.
    function automatic if_idx_t lowest_set(input logic [fetch_slot_cnt-1:0] mask);
        if_idx_t idx;
        idx = '0;
        for (int i = fetch_slot_cnt - 1; i >= 0; i--) begin
            if (mask[i]) idx = if_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fetch_tag_fifo.sv
// Small synchronous FIFO holding the slot index of each in-flight memory read.
// Its occupancy doubles as the outstanding-request counter.
module fetch_tag_fifo
    import fetch_port_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  if_idx_t       push_data_i,
    input  logic          pop_i,
    output if_idx_t       pop_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if_idx_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_port_arbiter.sv
// Shares one I-memory read port among the IF fetch slots: accepts a batch,
// issues enabled slots in ascending order and gathers in-order responses.
module fetch_port_arbiter
    import fetch_port_arbiter_pkg::*;
#(
    parameter  int unsigned max_outst = 2,
    localparam int unsigned OUTST_W   = $clog2(max_outst + 1),
    localparam int unsigned N         = fetch_slot_cnt
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   batch_valid_i,
    output logic                   batch_ready_o,
    input  logic [N-1:0]           batch_en_i,
    input  addr_t [N-1:0]          batch_pc_i,
    input  logic                   flush_i,
    output logic                   mem_req_valid_o,
    output addr_t                  mem_req_addr_o,
    input  logic                   mem_req_ready_i,
    input  logic                   mem_rsp_valid_i,
    input  logic [31:0]            mem_rsp_data_i,
    output logic [N-1:0]           slot_valid_o,
    output addr_t [N-1:0]          slot_pc_o,
    output logic [N-1:0][31:0]     slot_inst_o,
    output logic                   batch_done_o,
    output fetch_arb_state_t       state_o,
    output logic [OUTST_W-1:0]     outst_o
);

    fetch_arb_state_t     state_q, state_d;
    logic [N-1:0]         pend_q, pend_d;
    logic [N-1:0]         slot_valid_q, slot_valid_d;
    addr_t [N-1:0]        slot_pc_q, slot_pc_d;
    logic [N-1:0][31:0]   slot_inst_q, slot_inst_d;
    logic                 done_q, done_d;

    logic [OUTST_W-1:0]   outst_q, outst_next;
    if_idx_t              issue_idx, tag_head;
    logic                 tag_full, tag_empty;
    logic                 req_valid, hs, rsp;

    assign issue_idx = lowest_set(pend_q);
    assign req_valid = (state_q == ARB_ISSUE) && (pend_q != '0) && !tag_full;
    assign hs        = req_valid && mem_req_ready_i;
    // A response with nothing in flight is illegal and simply ignored.
    assign rsp       = mem_rsp_valid_i && !tag_empty;

    fetch_tag_fifo #(.DEPTH(max_outst)) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (state_q == ARB_IDLE),
        .push_i      (hs),
        .push_data_i (issue_idx),
        .pop_i       (rsp),
        .pop_data_o  (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (outst_q)
    );

    always_comb begin
        outst_next = outst_q;
        if (hs && !rsp)      outst_next = outst_q + OUTST_W'(1);
        else if (!hs && rsp) outst_next = outst_q - OUTST_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_inst_d  = slot_inst_q;
        done_d       = 1'b0;

        if (hs) pend_d[issue_idx] = 1'b0;
        if (rsp && (state_q == ARB_ISSUE) && !flush_i) begin
            slot_inst_d[tag_head]  = mem_rsp_data_i;
            slot_valid_d[tag_head] = 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (flush_i) begin
                    slot_valid_d = '0;
                end else if (batch_valid_i) begin
                    pend_d       = batch_en_i;
                    slot_valid_d = '0;
                    for (int i = 0; i < N; i++) begin
                        slot_pc_d[i] = batch_en_i[i] ? batch_pc_i[i] : '0;
                    end
                    // An empty batch completes immediately without leaving IDLE.
                    if (batch_en_i == '0) done_d  = 1'b1;
                    else                  state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (flush_i) begin
                    pend_d       = '0;
                    slot_valid_d = '0;
                    state_d      = (outst_next != '0) ? ARB_DRAIN : ARB_IDLE;
                end else if ((pend_d == '0) && (outst_next == '0)) begin
                    state_d = ARB_IDLE;
                    done_d  = 1'b1;
                end
            end
            ARB_DRAIN: begin
                if (outst_next == '0) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            pend_q       <= '0;
            slot_valid_q <= '0;
            slot_pc_q    <= '0;
            slot_inst_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_inst_q  <= slot_inst_d;
            done_q       <= done_d;
        end
    end

    assign batch_ready_o   = (state_q == ARB_IDLE);
    assign mem_req_valid_o = req_valid;
    assign mem_req_addr_o  = ((state_q == ARB_ISSUE) && (pend_q != '0)) ? slot_pc_q[issue_idx] : '0;
    assign slot_valid_o    = slot_valid_q;
    assign slot_pc_o       = slot_pc_q;
    assign slot_inst_o     = slot_inst_q;
    assign batch_done_o    = done_q;
    assign state_o         = state_q;
    assign outst_o         = outst_q;

endmodule

// File: tb/tb_fetch_port_arbiter.sv
// Directed bench for fetch_port_arbiter with an in-order memory model and a
// request-address scoreboard.
module tb_fetch_port_arbiter;
    import fetch_port_arbiter_pkg::*;

    localparam int unsigned N         = fetch_slot_cnt;
    localparam int unsigned MAX_OUTST = 2;
    localparam int unsigned OW        = $clog2(MAX_OUTST + 1);

    logic               clk = 1'b0;
    logic               rst_i;
    logic               batch_valid_i;
    logic               batch_ready_o;
    logic [N-1:0]       batch_en_i;
    addr_t [N-1:0]      batch_pc_i;
    logic               flush_i;
    logic               mem_req_valid_o;
    addr_t              mem_req_addr_o;
    logic               mem_req_ready_i;
    logic               mem_rsp_valid_i;
    logic [31:0]        mem_rsp_data_i;
    logic [N-1:0]       slot_valid_o;
    addr_t [N-1:0]      slot_pc_o;
    logic [N-1:0][31:0] slot_inst_o;
    logic               batch_done_o;
    fetch_arb_state_t   state_o;
    logic [OW-1:0]      outst_o;

    fetch_port_arbiter #(.max_outst(MAX_OUTST)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .batch_valid_i   (batch_valid_i),
        .batch_ready_o   (batch_ready_o),
        .batch_en_i      (batch_en_i),
        .batch_pc_i      (batch_pc_i),
        .flush_i         (flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .slot_valid_o    (slot_valid_o),
        .slot_pc_o       (slot_pc_o),
        .slot_inst_o     (slot_inst_o),
        .batch_done_o    (batch_done_o),
        .state_o         (state_o),
        .outst_o         (outst_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        addr_t addr;
        int    remain;
    } rsp_t;

    rsp_t        mem_pipe[$];
    logic [31:0] exp_q[$];
    int          hs_cyc_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          latency = 1;

    function automatic logic [31:0] mem_word(input addr_t a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard the handshake at this edge, then drive memory response.
    task automatic tick();
        logic  hs;
        logic  r;
        addr_t a;
        rsp_t  e;
        hs = mem_req_valid_o && mem_req_ready_i;
        a  = mem_req_addr_o;
        r  = rst_i;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            mem_pipe.delete();
        end else if (hs) begin
            hs_cyc_q.push_back(cyc - 1);
            chk("req_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("req_addr", a, exp_q.pop_front());
            mem_pipe.push_back('{a, latency});
        end
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        foreach (mem_pipe[i]) if (mem_pipe[i].remain > 0) mem_pipe[i].remain--;
        if (mem_pipe.size() != 0 && mem_pipe[0].remain == 0) begin
            e = mem_pipe.pop_front();
            chk("rsp_in_flight", outst_o != 0, 1);
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(e.addr);
        end
        if (batch_done_o) done_cnt++;
        chk("outst_bound", outst_o <= MAX_OUTST, 1);
    endtask

    task automatic drive_batch(input logic [N-1:0] en, input addr_t [N-1:0] pcs, output int t);
        batch_en_i    = en;
        batch_pc_i    = pcs;
        batch_valid_i = 1'b1;
        for (int i = 0; i < N; i++) if (en[i]) exp_q.push_back(pcs[i]);
        hs_cyc_q.delete();
        t = cyc;
        tick();
        batch_valid_i = 1'b0;
        batch_en_i    = '0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        for (int k = 0; k < budget && !batch_done_o; k++) tick();
        chk("done_seen", batch_done_o, 1);
        dcyc = cyc;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_state"}, state_o, ARB_IDLE);
        chk({tag, "_ready"}, batch_ready_o, 1);
        chk({tag, "_req_valid"}, mem_req_valid_o, 0);
        chk({tag, "_req_addr"}, mem_req_addr_o, 0);
        chk({tag, "_slot_valid"}, slot_valid_o, 0);
        chk({tag, "_slot_pc"}, slot_pc_o, 0);
        chk({tag, "_slot_inst"}, slot_inst_o, 0);
        chk({tag, "_done"}, batch_done_o, 0);
        chk({tag, "_outst"}, outst_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int            t, d, dc;
        addr_t [N-1:0] pcs;

        rst_i = 1'b1; batch_valid_i = 1'b0; batch_en_i = '0; batch_pc_i = '0;
        flush_i = 1'b0; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        tick();
        tick();
        reset_check("reset");
        rst_i = 1'b0;
        tick();

        // Basic batch: slots 0,2,3 enabled, latency 1.
        latency = 1;
        pcs = '0; pcs[0] = 32'h100; pcs[1] = 32'hdead; pcs[2] = 32'h200; pcs[3] = 32'h300;
        drive_batch(4'b1101, pcs, t);
        chk("basic_first_req", mem_req_valid_o, 1);
        wait_done(20, d);
        chk("basic_done_cyc", d, t + 5);
        chk("basic_hs_n", hs_cyc_q.size(), 3);
        for (int i = 0; i < 3 && i < hs_cyc_q.size(); i++) chk("basic_hs_cyc", hs_cyc_q[i], t + 1 + i);
        chk("basic_valid", slot_valid_o, 4'b1101);
        chk("basic_inst0", slot_inst_o[0], mem_word(32'h100));
        chk("basic_inst2", slot_inst_o[2], mem_word(32'h200));
        chk("basic_inst3", slot_inst_o[3], mem_word(32'h300));
        chk("basic_pc1", slot_pc_o[1], 0);
        chk("basic_pc3", slot_pc_o[3], 32'h300);
        chk("basic_done_state", state_o, ARB_IDLE);
        tick();
        chk("basic_done_pulse", batch_done_o, 0);
        chk("basic_hold", slot_valid_o, 4'b1101);

        // Outstanding limit: latency 5, three slots.
        latency = 5;
        pcs = '0; pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
        drive_batch(4'b0111, pcs, t);
        tick(); tick();
        chk("limit_outst", outst_o, 2);
        chk("limit_hold_valid", mem_req_valid_o, 0);
        chk("limit_hold_addr", mem_req_addr_o, 32'h300);
        tick(); tick(); tick();
        chk("limit_hold_valid2", mem_req_valid_o, 0);
        chk("limit_hold_addr2", mem_req_addr_o, 32'h300);
        wait_done(40, d);
        chk("limit_done_cyc", d, t + 13);
        chk("limit_hs_n", hs_cyc_q.size(), 3);
        if (hs_cyc_q.size() == 3) chk("limit_third_hs", hs_cyc_q[2], t + 7);
        chk("limit_valid", slot_valid_o, 4'b0111);
        chk("limit_inst1", slot_inst_o[1], mem_word(32'h200));

        // Flush in IDLE wins over a simultaneous batch offer.
        tick();
        batch_valid_i = 1'b1; batch_en_i = 4'b0001; flush_i = 1'b1;
        tick();
        batch_valid_i = 1'b0; batch_en_i = '0; flush_i = 1'b0;
        chk("iflush_valid", slot_valid_o, 0);
        chk("iflush_state", state_o, ARB_IDLE);
        tick();
        chk("iflush_no_req", mem_req_valid_o, 0);

        // Backpressure: ready low for the first three request cycles.
        latency = 1;
        mem_req_ready_i = 1'b0;
        pcs = '0; pcs[0] = 32'h100; pcs[1] = 32'h200;
        drive_batch(4'b0011, pcs, t);
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", mem_req_valid_o, 1);
            chk("bp_addr", mem_req_addr_o, 32'h100);
            if (k < 3) tick();
        end
        mem_req_ready_i = 1'b1;
        wait_done(20, d);
        chk("bp_done_cyc", d, t + 7);
        chk("bp_hs_n", hs_cyc_q.size(), 2);
        chk("bp_valid_mask", slot_valid_o, 4'b0011);

        // Flush with two requests in flight.
        latency = 5;
        pcs = '0; pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
        drive_batch(4'b0111, pcs, t);
        tick(); tick();
        chk("fl_outst", outst_o, 2);
        dc = done_cnt;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_state", state_o, ARB_DRAIN);
        chk("fl_ready", batch_ready_o, 0);
        chk("fl_valid", slot_valid_o, 0);
        chk("fl_unissued", exp_q.size(), 1);
        exp_q.delete();
        tick(); tick(); tick();
        chk("fl_ready_t7", batch_ready_o, 0);
        tick();
        chk("fl_ready_t8", batch_ready_o, 1);
        chk("fl_idle", state_o, ARB_IDLE);
        chk("fl_valid_end", slot_valid_o, 0);
        chk("fl_no_done", done_cnt, dc);

        // Zero-enabled batch.
        pcs = '0; pcs[0] = 32'h900;
        drive_batch(4'b0000, pcs, t);
        chk("zero_done", batch_done_o, 1);
        chk("zero_state", state_o, ARB_IDLE);
        chk("zero_valid", slot_valid_o, 0);
        chk("zero_pc", slot_pc_o, 0);
        chk("zero_no_req", mem_req_valid_o, 0);
        tick();
        chk("zero_hs_n", hs_cyc_q.size(), 0);

        // Reset after the second issue.
        latency = 3;
        pcs[0] = 32'h400; pcs[1] = 32'h500; pcs[2] = 32'h600; pcs[3] = 32'h700;
        drive_batch(4'b1111, pcs, t);
        tick(); tick();
        chk("rst_pre_hs_n", hs_cyc_q.size(), 2);
        rst_i = 1'b1;
        tick();
        exp_q.delete();
        reset_check("midrst");
        rst_i = 1'b0;
        tick();

        // Arbiter resumes cleanly after reset.
        latency = 2;
        pcs = '0; pcs[0] = 32'h800;
        drive_batch(4'b0001, pcs, t);
        wait_done(20, d);
        chk("post_done_cyc", d, t + 4);
        chk("post_inst0", slot_inst_o[0], mem_word(32'h800));

        chk("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_port_arbiter.md
# fetch_port_arbiter

Shares the single instruction-memory read port among the `core::peval_width ** 2` IF fetch slots driven by the pipeline manager. It accepts one fetch batch (per-slot enable and PC), issues the enabled slots to memory in ascending slot order with a bounded number of outstanding requests, and collects the in-order responses into per-slot result registers. It signals batch completion and supports a flush that abandons a batch and drains in-flight responses. It sits between the pipeline manager's `if_en`/`if_pc` outputs and the I-memory.

## Interface
- `max_outst`, default 2: maximum requests in flight to memory; must be at least 1.
- `clk`  in  1  clock.
- `rst`  in  bool  synchronous, active-high reset.
- `batch_valid`  in  bool  a new fetch batch is offered.
- `batch_ready`  out  bool  the batch is accepted when `batch_valid && batch_ready`.
- `batch_en`  in  bool [N]  slot enabled in the offered batch (N = `core::fetch_slot_cnt`).
- `batch_pc`  in  `sys::addr_t` [N]  slot fetch address; already aligned, used as-is.
- `flush`  in  bool  abandon the current batch.
- `mem_req_valid`  out  bool  memory read request.
- `mem_req_addr`  out  `sys::addr_t`  request address.
- `mem_req_ready`  in  bool  memory accepts the request.
- `mem_rsp_valid`  in  bool  read data returned; responses arrive in request order.
- `mem_rsp_data`  in  32  instruction word.
- `slot_valid`  out  bool [N]  slot result captured.
- `slot_pc`  out  `sys::addr_t` [N]  slot PC latched at batch accept.
- `slot_inst`  out  32 [N]  slot instruction.
- `batch_done`  out  bool  one-cycle pulse when every enabled slot has been captured.

## Operation
- **State machine:** `IDLE`, `ISSUE`, `DRAIN`.
- **Registers:** `pend` is an N-bit mask of slots not yet issued. `outst` counts requests in flight (0..`max_outst`). A tag FIFO holds the slot index of each in-flight request.
- **`IDLE`:**
  - `batch_ready` = 1.
  - On accept: `pend` = `batch_en`; `slot_pc[i]` = `batch_pc[i]` if enabled, else 0; all `slot_valid` cleared; state goes to `ISSUE`.
- **`ISSUE`:**
  - `mem_req_valid` = (`pend` != 0) && (`outst` < `max_outst`).
  - `mem_req_addr` = `slot_pc` of the lowest set bit of `pend`.
  - On handshake: clear that `pend` bit, push its index to the tag FIFO, increment `outst`.
- **Response:** pop the tag, write `slot_inst[tag]`, set `slot_valid[tag]`, decrement `outst`. A handshake and a response in the same cycle leave `outst` unchanged.
- **Completion:** when `pend` == 0 and `outst` == 0 after this cycle's updates, the next cycle has `batch_done` = 1 and state `IDLE`. Slot outputs hold until the next accept or flush.
- **Zero-enabled batch:** `batch_done` pulses the cycle after accept.
- **`flush` in `ISSUE`:**
  - `pend` cleared, all `slot_valid` cleared, no `batch_done`.
  - Next state is `DRAIN` if post-update `outst` > 0, else `IDLE`.
  - A handshake in the flush cycle still counts as issued and is drained later.
  - A response in the flush cycle is discarded.
- **`DRAIN`:**
  - `batch_ready` = 0 and `mem_req_valid` = 0.
  - Responses are popped and discarded.
  - Go to `IDLE` when `outst` reaches 0; `flush` here has no further effect.
- **`flush` in `IDLE`:** clears `slot_valid` and has priority over `batch_valid`, so no accept occurs that cycle.
- **Illegal inputs:**
  - `mem_rsp_valid` with `outst` == 0 is ignored; the bench asserts it never happens.
  - `batch_valid` while not ready is ignored.

## Timing
- Reset values, from the cycle after `rst` is sampled:
  - state `IDLE`, `batch_ready` 1;
  - `mem_req_valid` 0, `mem_req_addr` 0;
  - all `slot_valid` 0, `slot_pc` 0, `slot_inst` 0;
  - `batch_done` 0, `outst` 0, tag FIFO empty.
- Reset mid-batch abandons everything. Memory shares `rst`, so no stale responses are expected.
- If accept happens at cycle T, the first `mem_req_valid` is at T+1.
- With `mem_req_ready` held high, enabled slots issue one per cycle.
- While `mem_req_ready` is low, `mem_req_valid` and `mem_req_addr` stay stable until handshake; `flush` may withdraw the request.
- Response capture is registered: `slot_valid` rises the cycle after `mem_rsp_valid`.
- `batch_done` is asserted the cycle after the last capture, together with the return to `IDLE`. A new batch can be accepted in that same cycle.

## Structure
- **Additions to the `core` package:**
  - `fetch_slot_cnt` = `peval_width ** 2`;
  - `fetch_arb_state_t` enum;
  - reuse of `if_idx_t` for tags.
- **Sub-module `fetch_tag_fifo`:** synchronous FIFO, depth `max_outst`, width `if_idx_t`, with push/pop, full/empty flags and a clear input.

## Test plan
- **Basic batch:** `peval_width`=2, `en`={1,0,1,1}, PCs 0x100/–/0x200/0x300, ready=1, latency 1, accept at T.
  - Requests 0x100, 0x200, 0x300 at T+1..T+3.
  - `batch_done` at T+5.
  - `slot_valid`={1,0,1,1} with matching `slot_inst`.
- **Outstanding limit:** `max_outst`=2, latency 5, three slots.
  - Third request held with addr 0x300 stable until the first response.
  - `outst` never exceeds 2.
- **Backpressure:** `mem_req_ready` low for 3 cycles on the first request.
  - Addr 0x100 held stable, then exactly one handshake per slot, with no duplicates.
- **Flush with two in flight:**
  - Enters `DRAIN`; `batch_ready`=0 until both responses arrive, then 1.
  - All `slot_valid` 0 and no `batch_done`.
- **Zero-enabled batch:** accept at T with all enables 0.
  - `batch_done`=1 at T+1, no memory requests, all `slot_valid` 0.
- **Reset mid-`ISSUE`:** `rst` after the second issue.
  - Next cycle: `IDLE`, `batch_ready`=1, `mem_req_valid`=0, all outputs at their reset values.
